// File: rtl/tpu_csr_bank_if.sv
// Register-file bus between a CSR master and tpu_csr_bank: write strobe, shared
// address, write data, write-ready and registered read data.
interface tpu_csr_bank_if;
  logic       we_rf;
  logic [7:0] addr_rf;
  logic [7:0] data_rf;
  logic       ready_rf;
  logic [7:0] data_out;

  modport master (output we_rf, addr_rf, data_rf, input ready_rf, data_out);
  modport slave  (input we_rf, addr_rf, data_rf, output ready_rf, data_out);
endinterface

// File: rtl/tpu_csr_bank.sv
// TPU control/status register bank: CTRL, per-channel TX/RX slots, double-buffered timer value, STATUS.
// Macro TPU_CSR_SLOT_PROTECT_EN defers slot writes that target the slot currently matching TIME.
module tpu_csr_bank #(
  parameter int unsigned N_CH      = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h20
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  tpu_csr_bank_if.slave     bus,
  input  logic              TPUINT_RF,
  input  logic [7:0]        TIME,
  output logic              RSTTPU,
  output logic              TXSLOT_EN,
  output logic              RXSLOT_EN,
  output logic              TIMERINTMSK,
  output logic              INTFLAG,
  output logic [8*N_CH-1:0] TX_SLOT,
  output logic [8*N_CH-1:0] RX_SLOT,
  output logic [15:0]       TIMER_INT_VALUE
);
  localparam int unsigned IW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [7:0]  OFF_HI = 8'(2*N_CH+1);
  localparam logic [7:0]  OFF_LO = 8'(2*N_CH+2);
  localparam logic [7:0]  OFF_ST = 8'(2*N_CH+3);

  logic [7:0]  r_tx [N_CH];
  logic [7:0]  r_rx [N_CH];
  logic        r_txen, r_rxen, r_msk, r_intflag, r_rsttpu, r_tpuint_d;
  logic [7:0]  r_shadow;
  logic        r_shadow_vld;
  logic [15:0] r_timer;
  logic [7:0]  r_data_out;

  logic [8:0]    w_off9;
  logic [7:0]    w_off;
  logic          w_mapped, w_wr_acc;
  logic          w_wr_ctrl, w_wr_hi, w_wr_lo, w_wr_slot, w_wr_rx;
  logic [IW-1:0] w_wr_idx;
  logic          w_pending, w_cm_en, w_cm_rx;
  logic [IW-1:0] w_cm_idx;
  logic [7:0]    w_cm_data;
  logic [7:0]    w_rdata;

  // 9-bit subtraction so addresses below BASE_ADDR show up as a borrow
  assign w_off9       = {1'b0, bus.addr_rf} - {1'b0, BASE_ADDR};
  assign w_off        = w_off9[7:0];
  assign w_mapped     = ~w_off9[8] && (w_off <= OFF_ST);
  assign bus.ready_rf = ~RST & ~w_pending;
  assign w_wr_acc     = bus.we_rf & bus.ready_rf & w_mapped;

  always_comb begin
    w_wr_ctrl = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    w_wr_slot = 1'b0;
    w_wr_rx   = 1'b0;
    w_wr_idx  = '0;
    if (w_wr_acc) begin
      w_wr_ctrl = (w_off == 8'd0);
      w_wr_hi   = (w_off == OFF_HI);
      w_wr_lo   = (w_off == OFF_LO);
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_off == 8'(2*i+1)) begin
        w_wr_slot = w_wr_acc;
        w_wr_rx   = 1'b0;
        w_wr_idx  = IW'(i);
      end
      if (w_off == 8'(2*i+2)) begin
        w_wr_slot = w_wr_acc;
        w_wr_rx   = 1'b1;
        w_wr_idx  = IW'(i);
      end
    end
  end

`ifdef TPU_CSR_SLOT_PROTECT_EN
  typedef enum logic {S_IDLE, S_PEND} state_t;
  state_t        r_state, w_state_nxt;
  logic          r_h_rx;
  logic [IW-1:0] r_h_idx;
  logic [7:0]    r_h_data;
  logic [7:0]    w_wr_cur, w_held_cur;
  logic          w_hold;

  assign w_pending = (r_state == S_PEND);

  always_comb begin
    w_wr_cur   = '0;
    w_held_cur = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_wr_idx == IW'(i)) w_wr_cur   = w_wr_rx ? r_rx[i] : r_tx[i];
      if (r_h_idx == IW'(i))  w_held_cur = r_h_rx  ? r_rx[i] : r_tx[i];
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_h_rx   <= 1'b0;
      r_h_idx  <= '0;
      r_h_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold) begin
        r_h_rx   <= w_wr_rx;
        r_h_idx  <= w_wr_idx;
        r_h_data <= bus.data_rf;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold      = 1'b0;
    w_cm_en     = 1'b0;
    w_cm_rx     = w_wr_rx;
    w_cm_idx    = w_wr_idx;
    w_cm_data   = bus.data_rf;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_slot) begin
          if ((w_wr_rx ? r_rxen : r_txen) && (TIME == w_wr_cur)) begin
            w_hold      = 1'b1;
            w_state_nxt = S_PEND;
          end else begin
            w_cm_en = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (TIME != w_held_cur) begin
          w_cm_en     = 1'b1;
          w_cm_rx     = r_h_rx;
          w_cm_idx    = r_h_idx;
          w_cm_data   = r_h_data;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end
`else
  assign w_pending = 1'b0;
  assign w_cm_en   = w_wr_slot;
  assign w_cm_rx   = w_wr_rx;
  assign w_cm_idx  = w_wr_idx;
  assign w_cm_data = bus.data_rf;
`endif

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_txen       <= 1'b0;
      r_rxen       <= 1'b0;
      r_msk        <= 1'b0;
      r_intflag    <= 1'b0;
      r_rsttpu     <= 1'b0;
      r_tpuint_d   <= 1'b0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_timer      <= '0;
      r_data_out   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_tx[i] <= '0;
        r_rx[i] <= '0;
      end
    end else begin
      r_tpuint_d <= TPUINT_RF;
      r_rsttpu   <= w_wr_ctrl & bus.data_rf[0];
      if (w_wr_ctrl) begin
        r_txen <= bus.data_rf[1];
        r_rxen <= bus.data_rf[2];
        r_msk  <= bus.data_rf[3];
      end
      // a new interrupt edge beats a simultaneous W1C
      if (TPUINT_RF & ~r_tpuint_d)           r_intflag <= 1'b1;
      else if (w_wr_ctrl & bus.data_rf[4])   r_intflag <= 1'b0;
      if (w_wr_hi) begin
        r_shadow     <= bus.data_rf;
        r_shadow_vld <= 1'b1;
      end
      if (w_wr_lo) begin
        r_timer      <= {r_shadow, bus.data_rf};
        r_shadow_vld <= 1'b0;
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_cm_en && (w_cm_idx == IW'(i))) begin
          if (w_cm_rx) r_rx[i] <= w_cm_data;
          else         r_tx[i] <= w_cm_data;
        end
      end
      r_data_out <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_mapped) begin
      if (w_off == 8'd0)  w_rdata = {3'b000, r_intflag, r_msk, r_rxen, r_txen, 1'b0};
      if (w_off == OFF_HI) w_rdata = r_timer[15:8];
      if (w_off == OFF_LO) w_rdata = r_timer[7:0];
      if (w_off == OFF_ST) w_rdata = {6'b000000, r_shadow_vld, w_pending};
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_off == 8'(2*i+1)) w_rdata = r_tx[i];
        if (w_off == 8'(2*i+2)) w_rdata = r_rx[i];
      end
    end
  end

  always_comb begin
    TX_SLOT = '0;
    RX_SLOT = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      TX_SLOT[8*i +: 8] = r_tx[i];
      RX_SLOT[8*i +: 8] = r_rx[i];
    end
  end

  assign RSTTPU          = r_rsttpu;
  assign TXSLOT_EN       = r_txen;
  assign RXSLOT_EN       = r_rxen;
  assign TIMERINTMSK     = r_msk;
  assign INTFLAG         = r_intflag;
  assign TIMER_INT_VALUE = r_timer;
  assign bus.data_out    = r_data_out;
endmodule

// File: tb/tb_tpu_csr_bank.sv
// Self-checking bench for tpu_csr_bank (N_CH=2, BASE_ADDR=8'h20); read data is scoreboarded
// through a queue filled when an address is driven and drained one cycle later.
module tb_tpu_csr_bank;
  logic        SYS_CLK = 1'b0;
  logic        RST;
  logic        TPUINT_RF;
  logic [7:0]  TIME;
  logic        RSTTPU, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG;
  logic [15:0] TX_SLOT, RX_SLOT;
  logic [15:0] TIMER_INT_VALUE;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_q  [$];
  logic [7:0]  addr_q [$];

  tpu_csr_bank_if bus ();

  tpu_csr_bank #(.N_CH(2), .BASE_ADDR(8'h20)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .bus(bus), .TPUINT_RF(TPUINT_RF), .TIME(TIME),
    .RSTTPU(RSTTPU), .TXSLOT_EN(TXSLOT_EN), .RXSLOT_EN(RXSLOT_EN),
    .TIMERINTMSK(TIMERINTMSK), .INTFLAG(INTFLAG), .TX_SLOT(TX_SLOT), .RX_SLOT(RX_SLOT),
    .TIMER_INT_VALUE(TIMER_INT_VALUE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.we_rf = 1'b1; bus.addr_rf = a; bus.data_rf = d;
    @(negedge SYS_CLK);
    bus.we_rf = 1'b0;
  endtask

  task automatic push_rd(input logic [7:0] a, input logic [7:0] e);
    bus.addr_rf = a;
    addr_q.push_back(a);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] a, e;
    repeat (2) @(negedge SYS_CLK);
    n_tests++; if (bus.ready_rf !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b expected 0", bus.ready_rf); end
    n_tests++; if ({RSTTPU, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG} !== 5'b0) begin n_fail++;
      $display("FAIL rst_ctrl_outs: got %b expected 00000", {RSTTPU, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG}); end
    n_tests++; if ({TX_SLOT, RX_SLOT, TIMER_INT_VALUE} !== 48'h0) begin n_fail++;
      $display("FAIL rst_regs: got %h expected 0", {TX_SLOT, RX_SLOT, TIMER_INT_VALUE}); end
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h expected 00", bus.data_out); end
    RST = 1'b0;
    #1;
    n_tests++; if (bus.ready_rf !== 1'b1) begin n_fail++; $display("FAIL rst_ready_release: got %b expected 1", bus.ready_rf); end
    push_rd(8'h20, 8'h00);
    @(negedge SYS_CLK);
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL rst_rd_%h: got %h expected %h", a, bus.data_out, e); end
  endtask

  task automatic test_slot_map();
    logic [7:0] ra [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h1F, 8'h28, 8'h27, 8'h00};
    logic [7:0] re [8] = '{8'h11, 8'h22, 8'h05, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] a, e;
    wr(8'h23, 8'h05);
    n_tests++; if (TX_SLOT !== 16'h0500) begin n_fail++; $display("FAIL slot_tx1: got %h expected 0500", TX_SLOT); end
    n_tests++; if (RX_SLOT !== 16'h0000) begin n_fail++; $display("FAIL slot_rx_untouched: got %h expected 0000", RX_SLOT); end
    wr(8'h21, 8'h11); wr(8'h22, 8'h22); wr(8'h24, 8'h44);
    wr(8'h27, 8'hFF); wr(8'h28, 8'hAA); wr(8'h1F, 8'hBB);
    n_tests++; if ({TX_SLOT, RX_SLOT} !== 32'h0511_4422) begin n_fail++;
      $display("FAIL slot_dropped_writes: got %h expected 05114422", {TX_SLOT, RX_SLOT}); end
    n_tests++; if ({TIMER_INT_VALUE, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG} !== 20'h0) begin n_fail++;
      $display("FAIL slot_no_side_effect: got %h expected 0", {TIMER_INT_VALUE, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG}); end
    for (int k = 0; k < 8; k++) begin
      push_rd(ra[k], re[k]);
      @(negedge SYS_CLK);
      a = addr_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL slot_rd_%h: got %h expected %h", a, bus.data_out, e); end
    end
  endtask

  task automatic test_ctrl();
    logic [7:0] a, e;
    wr(8'h20, 8'h01);
    n_tests++; if (RSTTPU !== 1'b1) begin n_fail++; $display("FAIL ctrl_rsttpu_pulse: got %b expected 1", RSTTPU); end
    push_rd(8'h20, 8'h00);
    @(negedge SYS_CLK);
    n_tests++; if (RSTTPU !== 1'b0) begin n_fail++; $display("FAIL ctrl_rsttpu_end: got %b expected 0", RSTTPU); end
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL ctrl_rd_bit0_%h: got %h expected %h", a, bus.data_out, e); end
    wr(8'h20, 8'hEE);
    n_tests++; if ({RSTTPU, INTFLAG, TIMERINTMSK, RXSLOT_EN, TXSLOT_EN} !== 5'b00111) begin n_fail++;
      $display("FAIL ctrl_bits: got %b expected 00111", {RSTTPU, INTFLAG, TIMERINTMSK, RXSLOT_EN, TXSLOT_EN}); end
    push_rd(8'h20, 8'h0E);
    @(negedge SYS_CLK);
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL ctrl_rd_%h: got %h expected %h", a, bus.data_out, e); end
    wr(8'h20, 8'h00);
    n_tests++; if ({TIMERINTMSK, RXSLOT_EN, TXSLOT_EN} !== 3'b000) begin n_fail++;
      $display("FAIL ctrl_clear: got %b expected 000", {TIMERINTMSK, RXSLOT_EN, TXSLOT_EN}); end
  endtask

  task automatic test_intflag();
    logic [7:0] a, e;
    TPUINT_RF = 1'b1;
    wr(8'h20, 8'h10);
    n_tests++; if (INTFLAG !== 1'b1) begin n_fail++; $display("FAIL int_set_wins: got %b expected 1", INTFLAG); end
    push_rd(8'h20, 8'h10);
    @(negedge SYS_CLK);
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL int_rd_%h: got %h expected %h", a, bus.data_out, e); end
    wr(8'h20, 8'h10);
    n_tests++; if (INTFLAG !== 1'b0) begin n_fail++; $display("FAIL int_w1c: got %b expected 0", INTFLAG); end
    TPUINT_RF = 1'b0;
    @(negedge SYS_CLK);
    TPUINT_RF = 1'b1;
    @(negedge SYS_CLK);
    n_tests++; if (INTFLAG !== 1'b1) begin n_fail++; $display("FAIL int_edge_unmasked: got %b expected 1", INTFLAG); end
    @(negedge SYS_CLK);
    n_tests++; if (INTFLAG !== 1'b1) begin n_fail++; $display("FAIL int_level_hold: got %b expected 1", INTFLAG); end
    wr(8'h20, 8'h10);
    n_tests++; if (INTFLAG !== 1'b0) begin n_fail++; $display("FAIL int_w1c2: got %b expected 0", INTFLAG); end
    TPUINT_RF = 1'b0;
  endtask

  task automatic test_timer();
    logic [7:0] ra [5] = '{8'h25, 8'h27, 8'h25, 8'h26, 8'h27};
    logic [7:0] re [5] = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h00};
    logic [7:0] a, e;
    wr(8'h25, 8'hAB);
    n_tests++; if (TIMER_INT_VALUE !== 16'h0000) begin n_fail++; $display("FAIL tmr_shadow_only: got %h expected 0000", TIMER_INT_VALUE); end
    for (int k = 0; k < 2; k++) begin
      push_rd(ra[k], re[k]);
      @(negedge SYS_CLK);
      a = addr_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL tmr_rd_%h: got %h expected %h", a, bus.data_out, e); end
    end
    wr(8'h26, 8'hCD);
    n_tests++; if (TIMER_INT_VALUE !== 16'hABCD) begin n_fail++; $display("FAIL tmr_commit: got %h expected abcd", TIMER_INT_VALUE); end
    for (int k = 2; k < 5; k++) begin
      push_rd(ra[k], re[k]);
      @(negedge SYS_CLK);
      a = addr_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL tmr_rd_%h: got %h expected %h", a, bus.data_out, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa [4] = '{8'h21, 8'h22, 8'h25, 8'h26};
    logic [7:0] wd [4] = '{8'h31, 8'h32, 8'h12, 8'h34};
    logic [7:0] ra [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h20};
    logic [7:0] re [8] = '{8'h31, 8'h32, 8'h05, 8'h44, 8'h12, 8'h34, 8'h00, 8'h00};
    logic [7:0] a, e;
    bus.we_rf = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.addr_rf = wa[k]; bus.data_rf = wd[k];
      @(negedge SYS_CLK);
    end
    bus.we_rf = 1'b0;
    n_tests++; if ({TX_SLOT[7:0], RX_SLOT[7:0], TIMER_INT_VALUE} !== 32'h3132_1234) begin n_fail++;
      $display("FAIL b2b_writes: got %h expected 31321234", {TX_SLOT[7:0], RX_SLOT[7:0], TIMER_INT_VALUE}); end
    for (int k = 0; k < 8; k++) begin
      push_rd(ra[k], re[k]);
      @(negedge SYS_CLK);
      a = addr_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL b2b_rd_%h: got %h expected %h", a, bus.data_out, e); end
    end
  endtask

  task automatic test_protect();
    logic [7:0] a, e;
    wr(8'h20, 8'h02);
    wr(8'h21, 8'h07);
    n_tests++; if (TX_SLOT[7:0] !== 8'h07) begin n_fail++; $display("FAIL prot_setup: got %h expected 07", TX_SLOT[7:0]); end
    TIME = 8'h07;
`ifdef TPU_CSR_SLOT_PROTECT_EN
    wr(8'h21, 8'h09);
    n_tests++; if (bus.ready_rf !== 1'b0) begin n_fail++; $display("FAIL prot_ready_low: got %b expected 0", bus.ready_rf); end
    n_tests++; if (TX_SLOT[7:0] !== 8'h07) begin n_fail++; $display("FAIL prot_held: got %h expected 07", TX_SLOT[7:0]); end
    wr(8'h22, 8'h99);
    n_tests++; if (RX_SLOT[7:0] !== 8'h32) begin n_fail++; $display("FAIL prot_drop_while_pend: got %h expected 32", RX_SLOT[7:0]); end
    push_rd(8'h27, 8'h01);
    @(negedge SYS_CLK);
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL prot_status_%h: got %h expected %h", a, bus.data_out, e); end
    TIME = 8'h08;
    #1;
    n_tests++; if (bus.ready_rf !== 1'b0) begin n_fail++; $display("FAIL prot_commit_cycle_ready: got %b expected 0", bus.ready_rf); end
    @(negedge SYS_CLK);
    n_tests++; if ({TX_SLOT[7:0], bus.ready_rf} !== 9'h013) begin n_fail++;
      $display("FAIL prot_commit: got slot %h ready %b expected slot 09 ready 1", TX_SLOT[7:0], bus.ready_rf); end
    TIME = 8'h09;
    wr(8'h21, 8'h55);
    n_tests++; if (bus.ready_rf !== 1'b0) begin n_fail++; $display("FAIL prot_pend2: got %b expected 0", bus.ready_rf); end
    RST = 1'b1;
    @(negedge SYS_CLK);
    RST = 1'b0;
    #1;
    n_tests++; if ({TX_SLOT, bus.ready_rf} !== 17'h00001) begin n_fail++;
      $display("FAIL prot_rst_discard: got slot %h ready %b expected slot 0000 ready 1", TX_SLOT, bus.ready_rf); end
    TIME = 8'h20;
    repeat (2) @(negedge SYS_CLK);
    n_tests++; if (TX_SLOT[7:0] !== 8'h00) begin n_fail++; $display("FAIL prot_rst_lost: got %h expected 00", TX_SLOT[7:0]); end
`else
    wr(8'h21, 8'h09);
    n_tests++; if ({TX_SLOT[7:0], bus.ready_rf} !== 9'h013) begin n_fail++;
      $display("FAIL noprot_commit: got slot %h ready %b expected slot 09 ready 1", TX_SLOT[7:0], bus.ready_rf); end
    push_rd(8'h27, 8'h00);
    @(negedge SYS_CLK);
    a = addr_q.pop_front(); e = exp_q.pop_front();
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL noprot_status_%h: got %h expected %h", a, bus.data_out, e); end
    RST = 1'b1;
    @(negedge SYS_CLK);
    RST = 1'b0;
    #1;
    n_tests++; if ({TX_SLOT, RX_SLOT, bus.ready_rf} !== 33'h1) begin n_fail++;
      $display("FAIL noprot_rst: got tx %h rx %h ready %b expected 0 0 1", TX_SLOT, RX_SLOT, bus.ready_rf); end
`endif
  endtask

  initial begin
    RST = 1'b1; TPUINT_RF = 1'b0; TIME = 8'h00;
    bus.we_rf = 1'b0; bus.addr_rf = 8'h00; bus.data_rf = 8'h00;
    test_reset();
    test_slot_map();
    test_ctrl();
    test_intflag();
    test_timer();
    test_back_to_back();
    test_protect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_csr_bank.md
TPU_CSR_BANK -- requirements
Module: tpu_csr_bank

Interface
REQ-001 Parameter N_CH, default 2; number of TX/RX slot channel pairs, legal range 1..8.
REQ-002 Parameter BASE_ADDR, default 8'h20; address of CTRL; the map occupies BASE_ADDR..BASE_ADDR+2*N_CH+3.
REQ-003 SYS_CLK  in  1  clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 we_rf  in  1  write strobe, one write per asserted cycle.
REQ-006 addr_rf  in  8  register address, shared by read and write.
REQ-007 data_rf  in  8  write data.
REQ-008 TPUINT_RF  in  1  raw TPU interrupt source, level.
REQ-009 TIME  in  8  current TPU slot counter.
REQ-010 ready_rf  out  1  bank accepts writes.
REQ-011 RSTTPU  out  1  one-cycle TPU reset pulse.
REQ-012 TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG  out  1 each  CTRL bits 1, 2, 3, 4.
REQ-013 TX_SLOT, RX_SLOT  out  8*N_CH each  packed slot numbers, channel i at bits [8i+7:8i].
REQ-014 TIMER_INT_VALUE  out  16  committed timer interrupt value.
REQ-015 data_out  out  8  registered read data.

Function
REQ-016 Map: CTRL=BASE; TX_SLOT[i]=BASE+1+2i; RX_SLOT[i]=BASE+2+2i; TIMER_HI=BASE+2N_CH+1; TIMER_LO=BASE+2N_CH+2; STATUS=BASE+2N_CH+3 (read-only).
REQ-017 CTRL write: bits 1..3 load data_rf; bits 5..7 are ignored and read 0.
REQ-018 CTRL bit0 write of 1 shall assert RSTTPU for exactly the next cycle; bit0 reads 0.
REQ-019 INTFLAG shall set on a TPUINT_RF rising edge (registered previous value), regardless of TIMERINTMSK.
REQ-020 INTFLAG shall clear on a CTRL write with data_rf[4]=1 (W1C); if set and clear coincide, set wins.
REQ-021 TIMER_HI write loads an 8-bit shadow only; TIMER_LO write commits {shadow, data_rf} to TIMER_INT_VALUE in one cycle.
REQ-022 TIMER_HI reads the committed high byte, not the shadow.
REQ-023 data_out shall be valid one cycle after addr_rf; unmapped addresses read 8'h00.
REQ-024 STATUS read: bit0 = pending write, bit1 = shadow-loaded-not-committed, bits 7..2 = 0.
REQ-025 Writes with ready_rf=0 or to unmapped/STATUS addresses shall be dropped with no side effect.
REQ-026 ready_rf = ~RST & ~pending.

Reset
REQ-027 On RST all registers, shadow, pending state and TPUINT_RF edge history clear to 0; outputs 0 in the cycle after RST sampled high.
REQ-028 RST mid-pending shall discard the held write; ready_rf returns to 1 on the first cycle with RST low.

Configuration
REQ-029 Macro TPU_CSR_SLOT_PROTECT_EN defined: write to TX_SLOT[i] while TXSLOT_EN=1 and TIME==TX_SLOT[i] (RX analogous) enters PEND, holds address/data, drops ready_rf.
REQ-030 In PEND the held write shall commit in the first cycle TIME differs from the target's current value, then return to IDLE; ready_rf rises the cycle after commit.
REQ-031 Macro undefined: slot writes commit immediately, no PEND state exists, STATUS bit0 reads 0.

Verification
REQ-032 N_CH=2, write 8'h05 to BASE+3 -> RX_SLOT[7:0] unchanged, TX_SLOT[15:8]=8'h05 next cycle.
REQ-033 Write CTRL 8'h01 -> RSTTPU high exactly one cycle, CTRL readback 8'h00.
REQ-034 TPUINT_RF 0->1 in the cycle a CTRL 8'h10 write occurs -> INTFLAG=1; later write 8'h10 -> INTFLAG=0.
REQ-035 Write TIMER_HI 8'hAB, read TIMER_HI -> 8'h00, STATUS=8'h02; write TIMER_LO 8'hCD -> TIMER_INT_VALUE=16'hABCD.
REQ-036 PROTECT_EN, TXSLOT_EN=1, TX_SLOT[0]=8'h07, TIME=8'h07, write 8'h09 -> ready_rf=0, STATUS=8'h01; TIME->8'h08 -> TX_SLOT[0]=8'h09, ready_rf=1 next cycle.
REQ-037 Assert RST during PEND -> held write lost, TX_SLOT[0]=8'h00, ready_rf=1 after release.
